// File: rtl/scenario_delay_feeder_pkg.sv
// Shared types, default sizes and helpers for the scenario delay feeder.
package scenario_delay_feeder_pkg;

    localparam int N_OBJ_DEF     = 4;
    localparam int DELAY_LEN_DEF = 14;
    localparam int OBJ_ID_W_DEF  = 2;
    localparam int GAP_W_DEF     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SPACE,
        S_GAP,
        S_UPDATE
    } state_t;

    function automatic int clamp_n(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/scenario_delay_feeder_if.sv
// Issue bus from the feeder to the local controller / scenario NoC.
interface scenario_delay_feeder_if #(
    parameter int DW = 14,
    parameter int IW = 2
);
    logic          input_valid;
    logic          glob_scen_noc_input_valid;
    logic [DW-1:0] delay_matrix_element;
    logic [IW-1:0] obj_id_element;
    logic          boot_up_table_update;

    modport master (
        output input_valid,
        output glob_scen_noc_input_valid,
        output delay_matrix_element,
        output obj_id_element,
        output boot_up_table_update
    );

    modport slave (
        input input_valid,
        input glob_scen_noc_input_valid,
        input delay_matrix_element,
        input obj_id_element,
        input boot_up_table_update
    );
endinterface

// File: rtl/scenario_delay_feeder_dbuf.sv
// Shadow/active delay table pair; a write on the snapshot edge is captured.
module delay_table_dbuf #(
    parameter int N  = 4,
    parameter int DW = 14,
    parameter int IW = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          snap,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] shadow     [N];
    logic [DW-1:0] shadow_nxt [N];
    logic [DW-1:0] active     [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            shadow_nxt[i] = (wr_en && wr_addr == IW'(i)) ? wr_data : shadow[i];
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (snap) active[i] <= shadow_nxt[i];
            end
        end
    end

    // The first entry is fetched on the snapshot edge itself.
    assign rd_data = snap ? shadow_nxt[rd_idx] : active[rd_idx];

endmodule

// File: rtl/scenario_delay_feeder.sv
// Issues a snapshot of the delay table as boot or scenario-update strobes.
module scenario_delay_feeder
    import scenario_delay_feeder_pkg::*;
#(
    parameter int N_obj        = N_OBJ_DEF,
    parameter int delay_length = DELAY_LEN_DEF,
    parameter int obj_id_width = OBJ_ID_W_DEF,
    parameter int gap_width    = GAP_W_DEF
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [obj_id_width-1:0] cfg_addr,
    input  logic [delay_length-1:0] cfg_delay,
    input  logic [obj_id_width:0]   n_active,
    input  logic [gap_width-1:0]    gap_len,
    input  logic                    boot_req,
    input  logic                    scen_tick,
    scenario_delay_feeder_if.master feed,
    output logic                    busy,
    output logic                    err_overrun
);

    localparam int CW = obj_id_width + 1;

    state_t                  state, state_nxt;
    logic                    mode_boot;
    logic [CW-1:0]           rem;
    logic [CW-1:0]           n_clamp;
    logic [CW-1:0]           rd_cnt;
    logic [gap_width-1:0]    gap_cnt;
    logic [delay_length-1:0] elem_d;
    logic [obj_id_width-1:0] elem_id;
    logic [obj_id_width-1:0] rd_idx;
    logic [delay_length-1:0] rd_data;
    logic                    any_req;
    logic                    accept;
    logic                    load_elem;

    assign n_clamp = CW'(clamp_n(int'(n_active), N_obj));
    assign any_req = boot_req | scen_tick;
    assign accept  = (state == S_IDLE) && any_req;
    assign rd_cnt  = (state == S_IDLE) ? n_clamp : rem;
    assign rd_idx  = obj_id_width'(rd_cnt - CW'(1));

    delay_table_dbuf #(
        .N  (N_obj),
        .DW (delay_length),
        .IW (obj_id_width)
    ) u_tbl (
        .CLK     (CLK),
        .reset   (reset),
        .wr_en   (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_delay),
        .snap    (accept),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_elem = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (n_clamp != '0) begin
                        state_nxt = S_ISSUE;
                        load_elem = 1'b1;
                    end else begin
                        state_nxt = S_SPACE;
                    end
                end
            end
            S_ISSUE: state_nxt = S_SPACE;
            S_SPACE: begin
                if (rem != '0) begin
                    state_nxt = S_ISSUE;
                    load_elem = 1'b1;
                end else if (mode_boot) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = S_UPDATE;
                end else begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt <= gap_width'(1)) state_nxt = S_UPDATE;
            end
            S_UPDATE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mode_boot   <= 1'b0;
            rem         <= '0;
            gap_cnt     <= '0;
            elem_d      <= '0;
            elem_id     <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (accept) begin
                mode_boot <= boot_req;
                gap_cnt   <= gap_len;
                rem       <= n_clamp;
            end
            if (state == S_GAP) gap_cnt <= gap_cnt - gap_width'(1);
            if (load_elem) begin
                elem_d  <= rd_data;
                elem_id <= rd_idx;
                rem     <= rd_cnt - CW'(1);
            end
            // Dropped requests: busy, or scen_tick losing to boot_req.
            if (any_req && (!accept || (boot_req && scen_tick)))
                err_overrun <= 1'b1;
        end
    end

    assign feed.input_valid               = (state == S_ISSUE) && mode_boot;
    assign feed.glob_scen_noc_input_valid = (state == S_ISSUE) && !mode_boot;
    assign feed.boot_up_table_update      = (state == S_UPDATE);
    assign feed.delay_matrix_element      = elem_d;
    assign feed.obj_id_element            = elem_id;
    assign busy                           = (state != S_IDLE);

endmodule

// File: tb/tb_scenario_delay_feeder.sv
// Bench for scenario_delay_feeder: vector table, corner sequences, random runs.
module tb_scenario_delay_feeder;
    import scenario_delay_feeder_pkg::*;

    localparam int DW = 14;
    localparam int IW = 2;
    localparam int NO = 4;
    localparam int GW = 8;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic [IW:0]   n_active = '0;
    logic [GW-1:0] gap_len = '0;
    logic          boot_req = 1'b0;
    logic          scen_tick = 1'b0;
    logic          busy;
    logic          err_overrun;

    scenario_delay_feeder_if #(.DW(DW), .IW(IW)) feed ();

    scenario_delay_feeder #(
        .N_obj        (NO),
        .delay_length (DW),
        .obj_id_width (IW),
        .gap_width    (GW)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_delay   (cfg_delay),
        .n_active    (n_active),
        .gap_len     (gap_len),
        .boot_req    (boot_req),
        .scen_tick   (scen_tick),
        .feed        (feed),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          iv;
        logic          gv;
        logic          upd;
        logic          bsy;
        logic          err;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } obs_t;

    typedef struct {
        bit rb;
        int n;
        int gap;
        int blen;
        int nstr;
        int upd;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] shadow_m [NO];
    logic [DW-1:0] last_d;
    logic [IW-1:0] last_id;
    bit            ov_m;
    vec_t          vt [8];

    function automatic obs_t sample();
        obs_t o;
        o.iv  = feed.input_valid;
        o.gv  = feed.glob_scen_noc_input_valid;
        o.upd = feed.boot_up_table_update;
        o.bsy = busy;
        o.err = err_overrun;
        o.d   = feed.delay_matrix_element;
        o.id  = feed.obj_id_element;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NO; i++) shadow_m[i] = '0;
        last_d  = '0;
        last_id = '0;
        ov_m    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("rst_outs", 32'(sample()), 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int a, input int v);
        @(negedge CLK);
        cfg_we    = 1'b1;
        cfg_addr  = IW'(a);
        cfg_delay = DW'(v);
        shadow_m[a] = DW'(v);
        @(negedge CLK);
        cfg_we = 1'b0;
    endtask

    // inj_k: 0 none, 1 cfg write, 2 scen_tick, 3 boot_req; inj_c<0 picks a busy cycle
    task automatic run_seq(input bit rb, input bit rs, input int n, input int gap,
                           input int inj_c, input int inj_k, input int inj_a,
                           input int inj_v, output int blen, output int nstr,
                           output int upd_c, output int first_d);
        obs_t          exp_q [$];
        obs_t          e;
        obs_t          o;
        logic [DW-1:0] snap [NO];
        int            nc;
        int            ic;
        blen = 0; nstr = 0; upd_c = 0; first_d = -1;
        @(negedge CLK);
        boot_req  = rb;
        scen_tick = rs;
        n_active  = (IW+1)'(n);
        gap_len   = GW'(gap);
        if (inj_k == 1 && inj_c == 0) begin
            cfg_we = 1'b1; cfg_addr = IW'(inj_a); cfg_delay = DW'(inj_v);
            shadow_m[inj_a] = DW'(inj_v);
        end
        if (rb && rs) ov_m = 1'b1;
        snap = shadow_m;
        nc = (n > NO) ? NO : n;
        e = '0; e.bsy = 1'b1; e.d = last_d; e.id = last_id;
        for (int i = nc - 1; i >= 0; i--) begin
            e.iv = rb; e.gv = !rb; e.d = snap[i]; e.id = IW'(i);
            exp_q.push_back(e);
            e.iv = 1'b0; e.gv = 1'b0;
            exp_q.push_back(e);
        end
        if (nc == 0) exp_q.push_back(e);
        if (!rb) begin
            repeat (gap) exp_q.push_back(e);
            e.upd = 1'b1; exp_q.push_back(e); e.upd = 1'b0;
        end
        last_d = e.d; last_id = e.id;
        ic = inj_c;
        if (ic < 0) ic = $urandom_range(exp_q.size(), 1);
        e.bsy = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge CLK);
            cfg_we = 1'b0; boot_req = 1'b0; scen_tick = 1'b0;
            if (c == 1) begin
                n_active = (IW+1)'($urandom);
                gap_len  = GW'($urandom);
            end
            o = sample();
            e = exp_q[c-1];
            e.err = ov_m;
            chk($sformatf("cyc%0d", c), 32'(o), 32'(e));
            if (o.bsy) blen++;
            if (o.iv || o.gv) begin
                nstr++;
                if (first_d < 0) first_d = int'(o.d);
            end
            if (o.upd) upd_c = c;
            if (c == ic && ic > 0) begin
                case (inj_k)
                    1: begin
                        cfg_we = 1'b1; cfg_addr = IW'(inj_a); cfg_delay = DW'(inj_v);
                        shadow_m[inj_a] = DW'(inj_v);
                    end
                    2: begin scen_tick = 1'b1; ov_m = 1'b1; end
                    3: begin boot_req = 1'b1; ov_m = 1'b1; end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl, ns, uc, fd;
        vt[0] = '{0, 2, 4, 9, 2, 9};
        vt[1] = '{1, 2, 4, 4, 2, 0};
        vt[2] = '{0, 7, 0, 9, 4, 9};
        vt[3] = '{1, 0, 9, 1, 0, 0};
        vt[4] = '{0, 0, 0, 2, 0, 2};
        vt[5] = '{0, 0, 3, 5, 0, 5};
        vt[6] = '{0, 1, 1, 4, 1, 4};
        vt[7] = '{1, 4, 0, 8, 4, 0};

        model_reset();
        #3;
        chk("reset_state", 32'(sample()), 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;

        cfg_write(0, 10010);
        cfg_write(1, 10000);
        cfg_write(2, 7);
        cfg_write(3, 16383);
        for (int i = 0; i < 8; i++) begin
            run_seq(vt[i].rb, !vt[i].rb, vt[i].n, vt[i].gap, 0, 0, 0, 0,
                    bl, ns, uc, fd);
            chk($sformatf("v%0d_busy", i), 32'(bl), 32'(vt[i].blen));
            chk($sformatf("v%0d_strb", i), 32'(ns), 32'(vt[i].nstr));
            chk($sformatf("v%0d_upd", i), 32'(uc), 32'(vt[i].upd));
        end
        chk("no_overrun", 32'(err_overrun), 32'd0);

        run_seq(0, 1, 2, 4, 2, 2, 0, 0, bl, ns, uc, fd);
        chk("ovr_busy", 32'(bl), 32'd9);
        chk("ovr_upd", 32'(uc), 32'd9);
        repeat (3) @(negedge CLK);
        chk("ovr_sticky", 32'(err_overrun), 32'd1);

        do_reset();
        cfg_write(0, 10010);
        cfg_write(1, 10000);
        run_seq(0, 1, 2, 4, 2, 1, 1, 12000, bl, ns, uc, fd);
        chk("dbuf_cur", 32'(fd), 32'd10000);
        run_seq(0, 1, 2, 4, 0, 0, 0, 0, bl, ns, uc, fd);
        chk("dbuf_next", 32'(fd), 32'd12000);
        run_seq(0, 1, 2, 0, 0, 1, 1, 555, bl, ns, uc, fd);
        chk("same_edge_wr", 32'(fd), 32'd555);
        run_seq(1, 1, 2, 0, 0, 0, 0, 0, bl, ns, uc, fd);
        chk("both_boot", 32'(ns), 32'd2);
        chk("both_noupd", 32'(uc), 32'd0);
        chk("both_err", 32'(err_overrun), 32'd1);

        @(negedge CLK);
        scen_tick = 1'b1; n_active = 3'd2; gap_len = 8'd4;
        @(negedge CLK);
        scen_tick = 1'b0;
        chk("mid_c1_strb", 32'(feed.glob_scen_noc_input_valid), 32'd1);
        #2 reset = 1'b0;
        #1 chk("mid_rst_outs", 32'(sample()), 32'd0);
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
        for (int c = 3; c < 7; c++) begin
            @(negedge CLK);
            chk($sformatf("mid_quiet%0d", c), 32'(sample()), 32'd0);
        end
        cfg_write(1, 10000);
        run_seq(0, 1, 2, 4, 0, 0, 0, 0, bl, ns, uc, fd);
        chk("mid_clean_upd", 32'(uc), 32'd9);

        for (int r = 0; r < 40; r++) begin
            bit rb, rs;
            if ($urandom_range(3, 0) == 0)
                cfg_write($urandom_range(NO - 1, 0), $urandom_range(16383, 0));
            rb = 1'($urandom);
            rs = !rb || ($urandom_range(5, 0) == 0);
            run_seq(rb, rs, $urandom_range(7, 0), $urandom_range(5, 0), -1,
                    $urandom_range(3, 0), $urandom_range(NO - 1, 0),
                    $urandom_range(16383, 0), bl, ns, uc, fd);
            if ($urandom_range(4, 0) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
